// File: rtl/m68k_cycle_reporter.sv
// m68k_cycle_reporter
//   Turns each synchronised m68k bus cycle into a fixed byte frame on the
//   AVR UART transmit handshake. The frame carries header, address, a control
//   byte {fc, uds, lds, rw, to_flag, 0} and, for writes, the 16-bit data.
//
// Ports
//   clk_sys, rst        system clock, synchronous active-high reset
//   cycle_start         one-cycle pulse: AS asserted, addr/control stable
//   cycle_addr/fc/rw    sampled A[23:0], FC[2:0], R/W (1 = read)
//   cycle_uds/lds       data strobes, active-high
//   wdata_valid, wdata  one-cycle pulse with sampled D[15:0] for writes
//   tx_data, new_tx_data, tx_busy   byte offer handshake to avr_interface
//   busy                frame capture or transmission in progress
//   frame_done          one-cycle pulse after the last byte is accepted
//   drop_count          saturating count of cycle_start pulses seen while busy

module m68k_cycle_reporter #(
    parameter logic [7:0]  HDR_READ      = 8'h52,
    parameter logic [7:0]  HDR_WRITE     = 8'h57,
    parameter int unsigned WDATA_TIMEOUT = 255
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        cycle_start,
    input  logic [23:0] cycle_addr,
    input  logic [2:0]  cycle_fc,
    input  logic        cycle_rw,
    input  logic        cycle_uds,
    input  logic        cycle_lds,
    input  logic        wdata_valid,
    input  logic [15:0] wdata,
    output logic [7:0]  tx_data,
    output logic        new_tx_data,
    input  logic        tx_busy,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  drop_count
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_DATA = 2'd1;
    localparam logic [1:0] ST_SEND      = 2'd2;

    localparam logic [15:0] TIMEOUT_CNT = 16'(WDATA_TIMEOUT);

    logic [1:0]  state;
    logic [23:0] addr_q;
    logic [2:0]  fc_q;
    logic        rw_q;
    logic        uds_q;
    logic        lds_q;
    logic        to_flag_q;
    logic [15:0] data_q;
    logic [15:0] to_cnt;
    logic [2:0]  byte_idx;

    logic        accept;
    logic        last_byte;
    logic [7:0]  cur_byte;

    assign accept    = (state == ST_SEND) && !tx_busy;
    // Reads stop after the control byte; writes carry two data bytes more.
    assign last_byte = (byte_idx == (rw_q ? 3'd4 : 3'd6));

    always_comb begin
        cur_byte = 8'h00;
        case (byte_idx)
            3'd0:    cur_byte = rw_q ? HDR_READ : HDR_WRITE;
            3'd1:    cur_byte = addr_q[23:16];
            3'd2:    cur_byte = addr_q[15:8];
            3'd3:    cur_byte = addr_q[7:0];
            3'd4:    cur_byte = {fc_q, uds_q, lds_q, rw_q, to_flag_q, 1'b0};
            3'd5:    cur_byte = data_q[15:8];
            3'd6:    cur_byte = data_q[7:0];
            default: cur_byte = 8'h00;
        endcase
    end

    assign new_tx_data = (state == ST_SEND);
    // Keep the bus quiet outside SEND so the idle value is a clean zero.
    assign tx_data     = new_tx_data ? cur_byte : 8'h00;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            fc_q       <= '0;
            rw_q       <= 1'b0;
            uds_q      <= 1'b0;
            lds_q      <= 1'b0;
            to_flag_q  <= 1'b0;
            data_q     <= '0;
            to_cnt     <= '0;
            byte_idx   <= '0;
            frame_done <= 1'b0;
            drop_count <= '0;
        end else begin
            frame_done <= 1'b0;

            // Any start while a frame is in flight is lost, including the
            // cycle in which the last byte is being accepted.
            if (cycle_start && busy && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;

            case (state)
                ST_IDLE: begin
                    if (cycle_start) begin
                        addr_q    <= cycle_addr;
                        fc_q      <= cycle_fc;
                        rw_q      <= cycle_rw;
                        uds_q     <= cycle_uds;
                        lds_q     <= cycle_lds;
                        to_flag_q <= 1'b0;
                        to_cnt    <= '0;
                        byte_idx  <= '0;
                        state     <= cycle_rw ? ST_SEND : ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    // Data has priority over a timeout in the same cycle.
                    if (wdata_valid) begin
                        data_q   <= wdata;
                        byte_idx <= '0;
                        state    <= ST_SEND;
                    end else if (to_cnt == TIMEOUT_CNT) begin
                        data_q    <= 16'hFFFF;
                        to_flag_q <= 1'b1;
                        byte_idx  <= '0;
                        state     <= ST_SEND;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                ST_SEND: begin
                    if (accept) begin
                        if (last_byte) begin
                            state      <= ST_IDLE;
                            frame_done <= 1'b1;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
